// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert jump-command initiator.
package qbert_pkg;

  localparam int unsigned N_CUBE = 28;

  // Jump codes as carried on dir_code / e_jump_qb
  typedef enum logic [2:0] {
    JmpNone      = 3'b000,
    JmpDownRight = 3'b001,
    JmpDownLeft  = 3'b010,
    JmpUpRight   = 3'b011,
    JmpUpLeft    = 3'b100
  } jump_e;

  // Sprite layer state_qb codes
  localparam logic [2:0] QbStart  = 3'b000;
  localparam logic [2:0] QbJump   = 3'b001;
  localparam logic [2:0] QbIdle   = 3'b010;
  localparam logic [2:0] QbSaucer = 3'b011;
  localparam logic [2:0] QbKo     = 3'b100;

  // Controller FSM states
  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StMove,
    StKo,
    StGameOver
  } state_e;

  // Edge cubes; bit i-1 is cube i. Column 0 is the right edge, column r-1 the left edge.
  localparam logic [N_CUBE-1:0] TOP = 28'h000_0001;
  localparam logic [N_CUBE-1:0] R02 = 28'h000_0002;
  localparam logic [N_CUBE-1:0] R04 = 28'h000_0008;
  localparam logic [N_CUBE-1:0] R07 = 28'h000_0040;
  localparam logic [N_CUBE-1:0] R11 = 28'h000_0400;
  localparam logic [N_CUBE-1:0] R16 = 28'h000_8000;
  localparam logic [N_CUBE-1:0] R22 = 28'h020_0000;
  localparam logic [N_CUBE-1:0] L03 = 28'h000_0004;
  localparam logic [N_CUBE-1:0] L06 = 28'h000_0020;
  localparam logic [N_CUBE-1:0] L10 = 28'h000_0200;
  localparam logic [N_CUBE-1:0] L15 = 28'h000_4000;
  localparam logic [N_CUBE-1:0] L21 = 28'h010_0000;
  localparam logic [N_CUBE-1:0] L28 = 28'h800_0000;

  function automatic logic is_legal_dir(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  // One-hot of cube r(r-1)/2 + c + 1, i.e. bit r(r-1)/2 + c
  function automatic logic [N_CUBE-1:0] cube_onehot(input logic [2:0] r, input logic [2:0] c);
    logic [5:0] r6;
    logic [5:0] tri_n;
    logic [5:0] idx;
    r6    = {3'b000, r};
    tri_n = r6 * (r6 - 6'd1);
    idx   = (tri_n >> 1) + {3'b000, c};
    return {{(N_CUBE-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/qbert_cube_map.sv
// Combinational (row, col, dir) -> target cube one-hot plus off-pyramid flag.
module qbert_cube_map
  import qbert_pkg::*;
(
  input  logic [2:0]        row_i,
  input  logic [2:0]        col_i,
  input  logic [2:0]        dir_i,
  output logic [N_CUBE-1:0] next_o,
  output logic              bad_o,
  output logic [2:0]        next_row_o,
  output logic [2:0]        next_col_o
);

  logic [3:0] row_w;
  logic [3:0] col_w;
  logic [3:0] tr;
  logic [2:0] tc;

  // Target coordinates and legality; bad targets map to an all-zero mask
  always_comb begin
    row_w = {1'b0, row_i};
    col_w = {1'b0, col_i};
    tr    = row_w;
    tc    = col_i;
    bad_o = 1'b0;
    case (dir_i)
      JmpDownRight: tr = row_w + 4'd1;
      JmpDownLeft: begin
        tr = row_w + 4'd1;
        tc = col_i + 3'd1;
      end
      JmpUpRight: begin
        tr    = row_w - 4'd1;
        tc    = col_i - 3'd1;
        bad_o = (col_w == 4'd0);
      end
      JmpUpLeft: begin
        tr    = row_w - 4'd1;
        bad_o = (col_w + 4'd2 > row_w);  // c > r-2
      end
      default: bad_o = 1'b1;
    endcase
    if (tr == 4'd0 || tr == 4'd8) bad_o = 1'b1;
    next_row_o = tr[2:0];
    next_col_o = tc;
    next_o     = bad_o ? '0 : cube_onehot(tr[2:0], tc);
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump-command initiator: issues jumps to the sprite layer, commits landings,
// tracks visited cubes, lives and level clear.
module qbert_move_ctrl
  import qbert_pkg::*;
#(
  parameter int unsigned N_LIVES     = 3,
  parameter logic [31:0] ACK_TIMEOUT = 32'd1048575
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              dir_valid,
  input  logic [2:0]        dir_code,
  input  logic [2:0]        state_qb,
  input  logic              done_move,
  output logic [2:0]        e_jump_qb,
  output logic [N_CUBE-1:0] e_next_qb,
  output logic [N_CUBE-1:0] position_qb,
  output logic              e_bad_jump,
  output logic [N_CUBE-1:0] cube_done,
  output logic [1:0]        lives,
  output logic              level_clear,
  output logic              game_over,
  output logic              busy
);

  localparam logic [1:0] LivesInit = 2'(N_LIVES);

  state_e            state_q, state_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic [2:0]        tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
  logic [2:0]        e_jump_q, e_jump_d;
  logic [N_CUBE-1:0] e_next_q, e_next_d;
  logic [N_CUBE-1:0] position_q, position_d;
  logic              e_bad_q, e_bad_d;
  logic [N_CUBE-1:0] cube_done_q, cube_done_d;
  logic [1:0]        lives_q, lives_d;
  logic              level_clear_q, level_clear_d;
  logic              game_over_q, game_over_d;
  logic              busy_q, busy_d;
  logic              pend_valid_q, pend_valid_d;
  logic [2:0]        pend_code_q, pend_code_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              done_move_q;

  logic              dir_legal;
  logic              req_avail;
  logic [2:0]        req_code;
  logic              done_rise;
  logic [N_CUBE-1:0] map_next;
  logic              map_bad;
  logic [2:0]        map_row, map_col;

  assign dir_legal = dir_valid && is_legal_dir(dir_code);
  assign req_avail = dir_legal || pend_valid_q;
  // A fresh request is newer than anything buffered
  assign req_code  = dir_legal ? dir_code : pend_code_q;
  assign done_rise = done_move && !done_move_q;

  qbert_cube_map u_cube_map (
    .row_i      (row_q),
    .col_i      (col_q),
    .dir_i      (req_code),
    .next_o     (map_next),
    .bad_o      (map_bad),
    .next_row_o (map_row),
    .next_col_o (map_col)
  );

  // Next-state, buffer and output register computation
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    tgt_row_d     = tgt_row_q;
    tgt_col_d     = tgt_col_q;
    e_jump_d      = e_jump_q;
    e_next_d      = e_next_q;
    position_d    = position_q;
    e_bad_d       = e_bad_q;
    cube_done_d   = cube_done_q;
    lives_d       = lives_q;
    level_clear_d = 1'b0;
    game_over_d   = game_over_q;
    pend_valid_d  = pend_valid_q;
    pend_code_d   = pend_code_q;
    cnt_d         = cnt_q;

    if (cube_done_q == {N_CUBE{1'b1}}) begin
      cube_done_d   = TOP;
      level_clear_d = 1'b1;
    end

    // Any legal request not consumed below stays buffered (landing cycle included)
    if (dir_legal && state_q != StGameOver) begin
      pend_valid_d = 1'b1;
      pend_code_d  = dir_code;
    end

    unique case (state_q)
      StIdle: begin
        if (req_avail && state_qb == QbIdle) begin
          e_jump_d     = req_code;
          e_next_d     = map_next;
          e_bad_d      = map_bad;
          tgt_row_d    = map_row;
          tgt_col_d    = map_col;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 32'd1;
        if (state_qb == QbJump) begin
          state_d = StMove;
        end else if (cnt_q == ACK_TIMEOUT - 32'd1) begin
          e_jump_d = JmpNone;
          state_d  = StIdle;
        end
      end
      StMove: begin
        if (done_rise) begin
          if (!e_bad_q) begin
            position_d  = e_next_q;
            row_d       = tgt_row_q;
            col_d       = tgt_col_q;
            cube_done_d = cube_done_d | e_next_q;
            state_d     = StIdle;
          end else begin
            pend_valid_d = 1'b0;
            state_d      = StKo;
          end
        end
      end
      StKo: begin
        if (state_qb == QbStart) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            game_over_d = 1'b1;
            state_d     = StGameOver;
          end else begin
            // Keep e_next == position so the sprite layer cannot re-jump
            position_d = TOP;
            e_next_d   = TOP;
            e_jump_d   = JmpNone;
            e_bad_d    = 1'b0;
            row_d      = 3'd1;
            col_d      = 3'd0;
            state_d    = StIdle;
          end
        end
      end
      StGameOver: pend_valid_d = 1'b0;
      default:    state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);

    if (restart) begin
      state_d       = StIdle;
      row_d         = 3'd1;
      col_d         = 3'd0;
      tgt_row_d     = 3'd1;
      tgt_col_d     = 3'd0;
      e_jump_d      = JmpNone;
      e_next_d      = TOP;
      position_d    = TOP;
      e_bad_d       = 1'b0;
      cube_done_d   = TOP;
      lives_d       = LivesInit;
      level_clear_d = 1'b0;
      game_over_d   = 1'b0;
      busy_d        = 1'b0;
      pend_valid_d  = 1'b0;
      pend_code_d   = JmpNone;
      cnt_d         = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      row_q         <= 3'd1;
      col_q         <= 3'd0;
      tgt_row_q     <= 3'd1;
      tgt_col_q     <= 3'd0;
      e_jump_q      <= JmpNone;
      e_next_q      <= TOP;
      position_q    <= TOP;
      e_bad_q       <= 1'b0;
      cube_done_q   <= TOP;
      lives_q       <= LivesInit;
      level_clear_q <= 1'b0;
      game_over_q   <= 1'b0;
      busy_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_code_q   <= JmpNone;
      cnt_q         <= '0;
      done_move_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      tgt_row_q     <= tgt_row_d;
      tgt_col_q     <= tgt_col_d;
      e_jump_q      <= e_jump_d;
      e_next_q      <= e_next_d;
      position_q    <= position_d;
      e_bad_q       <= e_bad_d;
      cube_done_q   <= cube_done_d;
      lives_q       <= lives_d;
      level_clear_q <= level_clear_d;
      game_over_q   <= game_over_d;
      busy_q        <= busy_d;
      pend_valid_q  <= pend_valid_d;
      pend_code_q   <= pend_code_d;
      cnt_q         <= cnt_d;
      done_move_q   <= done_move;
    end
  end

  assign e_jump_qb   = e_jump_q;
  assign e_next_qb   = e_next_q;
  assign position_qb = position_q;
  assign e_bad_jump  = e_bad_q;
  assign cube_done   = cube_done_q;
  assign lives       = lives_q;
  assign level_clear = level_clear_q;
  assign game_over   = game_over_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Directed bench for qbert_move_ctrl: vector table plus hand-written corner sequences.
module tb_qbert_move_ctrl;
  import qbert_pkg::*;

  localparam logic [31:0] AckTo = 32'd16;

  logic        clk = 1'b0;
  logic        reset, restart, dir_valid, done_move;
  logic [2:0]  dir_code, state_qb;
  logic [2:0]  e_jump_qb;
  logic [27:0] e_next_qb, position_qb, cube_done;
  logic        e_bad_jump, level_clear, game_over, busy;
  logic [1:0]  lives;

  int n_vec  = 0;
  int n_fail = 0;

  qbert_move_ctrl #(
    .N_LIVES     (3),
    .ACK_TIMEOUT (AckTo)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .dir_valid   (dir_valid),
    .dir_code    (dir_code),
    .state_qb    (state_qb),
    .done_move   (done_move),
    .e_jump_qb   (e_jump_qb),
    .e_next_qb   (e_next_qb),
    .position_qb (position_qb),
    .e_bad_jump  (e_bad_jump),
    .cube_done   (cube_done),
    .lives       (lives),
    .level_clear (level_clear),
    .game_over   (game_over),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dir;
    logic [27:0] exp_next;
    logic        exp_bad;
    logic [27:0] exp_pos;
    logic [1:0]  exp_lives;
    logic [27:0] exp_done;
    logic        exp_go;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full jump handshake with a modelled sprite layer; checks the issued command
  task automatic do_jump(input logic [2:0] dir, input logic [27:0] exp_next,
                         input logic exp_bad, input string tag);
    dir_valid = 1'b1;
    dir_code  = dir;
    state_qb  = QbIdle;
    tick();
    dir_valid = 1'b0;
    check({tag, " e_jump"}, {29'd0, e_jump_qb}, {29'd0, dir});
    check({tag, " e_next"}, {4'd0, e_next_qb}, {4'd0, exp_next});
    check({tag, " e_bad"}, {31'd0, e_bad_jump}, {31'd0, exp_bad});
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    state_qb = QbJump;
    tick();
    done_move = 1'b1;
    tick();
    done_move = 1'b0;
    state_qb  = QbStart;
    tick();
    state_qb = QbIdle;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] walk[$];
    int r, c, n;
    logic [27:0] exp_oh;

    vecs[0] = '{JmpDownLeft,  28'h4,  1'b0, 28'h4,  2'd3, 28'h5,  1'b0};
    vecs[1] = '{JmpDownRight, 28'h10, 1'b0, 28'h10, 2'd3, 28'h15, 1'b0};
    vecs[2] = '{JmpUpRight,   28'h2,  1'b0, 28'h2,  2'd3, 28'h17, 1'b0};
    vecs[3] = '{JmpUpRight,   28'h0,  1'b1, 28'h1,  2'd2, 28'h17, 1'b0};
    vecs[4] = '{JmpUpLeft,    28'h0,  1'b1, 28'h1,  2'd1, 28'h17, 1'b0};
    vecs[5] = '{JmpDownRight, 28'h2,  1'b0, 28'h2,  2'd1, 28'h17, 1'b0};
    vecs[6] = '{JmpDownLeft,  28'h10, 1'b0, 28'h10, 2'd1, 28'h17, 1'b0};
    vecs[7] = '{JmpUpLeft,    28'h4,  1'b0, 28'h4,  2'd1, 28'h17, 1'b0};
    vecs[8] = '{JmpDownLeft,  28'h20, 1'b0, 28'h20, 2'd1, 28'h37, 1'b0};
    vecs[9] = '{JmpUpLeft,    28'h0,  1'b1, 28'h20, 2'd0, 28'h37, 1'b1};

    reset = 1'b1; restart = 1'b0; dir_valid = 1'b0; dir_code = 3'd0;
    state_qb = QbIdle; done_move = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst position", {4'd0, position_qb}, 32'h1);
    check("rst e_next", {4'd0, e_next_qb}, 32'h1);
    check("rst cube_done", {4'd0, cube_done}, 32'h1);
    check("rst e_jump", {29'd0, e_jump_qb}, 32'd0);
    check("rst e_bad", {31'd0, e_bad_jump}, 32'd0);
    check("rst lives", {30'd0, lives}, 32'd3);
    check("rst flags", {29'd0, level_clear, game_over, busy}, 32'd0);

    // Table: good/bad jumps, lives down to game over
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      do_jump(vecs[i].dir, vecs[i].exp_next, vecs[i].exp_bad, tag);
      check({tag, " position"}, {4'd0, position_qb}, {4'd0, vecs[i].exp_pos});
      check({tag, " lives"}, {30'd0, lives}, {30'd0, vecs[i].exp_lives});
      check({tag, " cube_done"}, {4'd0, cube_done}, {4'd0, vecs[i].exp_done});
      check({tag, " game_over"}, {31'd0, game_over}, {31'd0, vecs[i].exp_go});
    end

    // Requests are dropped in game over
    dir_valid = 1'b1; dir_code = JmpDownRight; state_qb = QbIdle;
    tick();
    dir_valid = 1'b0;
    tick();
    tick();
    check("go position", {4'd0, position_qb}, 32'h20);
    check("go e_next", {4'd0, e_next_qb}, 32'h0);
    check("go held", {30'd0, game_over, busy}, 32'd3);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart lives", {30'd0, lives}, 32'd3);
    check("restart game_over", {31'd0, game_over}, 32'd0);
    check("restart position", {4'd0, position_qb}, 32'h1);
    check("restart cube_done", {4'd0, cube_done}, 32'h1);
    check("restart busy", {31'd0, busy}, 32'd0);

    // Buffered request: overwritten during MOVE, last one arrives on the landing cycle
    dir_valid = 1'b1; dir_code = JmpDownRight; state_qb = QbIdle;
    tick();
    dir_valid = 1'b0; state_qb = QbJump;
    tick();
    dir_valid = 1'b1; dir_code = JmpDownRight;
    tick();
    dir_code = JmpDownLeft; done_move = 1'b1;
    tick();
    dir_valid = 1'b0; done_move = 1'b0; state_qb = QbIdle;
    check("buf land position", {4'd0, position_qb}, 32'h2);
    tick();
    check("buf e_jump", {29'd0, e_jump_qb}, {29'd0, JmpDownLeft});
    check("buf e_next", {4'd0, e_next_qb}, 32'h10);
    check("buf busy", {31'd0, busy}, 32'd1);
    state_qb = QbJump;
    tick();
    done_move = 1'b1;
    tick();
    done_move = 1'b0; state_qb = QbIdle;
    tick();
    check("buf2 position", {4'd0, position_qb}, 32'h10);
    check("buf2 busy", {31'd0, busy}, 32'd0);

    // Acknowledge timeout: sprite layer never reports JUMP
    dir_valid = 1'b1; dir_code = JmpDownRight; state_qb = QbIdle;
    tick();
    dir_valid = 1'b0;
    check("to e_next", {4'd0, e_next_qb}, 32'h80);
    n = 0;
    while (busy && n < int'(AckTo) + 8) begin
      tick();
      n++;
    end
    check("to wait window", {31'd0, (n >= int'(AckTo) - 1) && (n <= int'(AckTo) + 1)}, 32'd1);
    check("to e_jump", {29'd0, e_jump_qb}, 32'd0);
    check("to busy", {31'd0, busy}, 32'd0);
    check("to position", {4'd0, position_qb}, 32'h10);

    // Walk every cube row by row from TOP
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int row = 2; row <= 7; row++) begin
      if (row % 2 == 0) begin
        walk.push_back(JmpDownRight);
        for (int k = 0; k < row - 1; k++) begin
          walk.push_back(JmpUpLeft);
          walk.push_back(JmpDownLeft);
        end
      end else begin
        walk.push_back(JmpDownLeft);
        for (int k = 0; k < row - 1; k++) begin
          walk.push_back(JmpUpRight);
          walk.push_back(JmpDownRight);
        end
      end
    end
    r = 1;
    c = 0;
    for (int i = 0; i < walk.size(); i++) begin
      case (walk[i])
        JmpDownRight: r = r + 1;
        JmpDownLeft:  begin r = r + 1; c = c + 1; end
        JmpUpRight:   begin r = r - 1; c = c - 1; end
        default:      r = r - 1;
      endcase
      exp_oh = 28'd1 << (r * (r - 1) / 2 + c);
      if (i == walk.size() - 1)
        check("walk pre-final cube_done", {4'd0, cube_done}, 32'hFDF_FFFF);
      do_jump(walk[i], exp_oh, 1'b0, $sformatf("walk%0d", i));
      check($sformatf("walk%0d position", i), {4'd0, position_qb}, {4'd0, exp_oh});
    end
    check("walk level_clear", {31'd0, level_clear}, 32'd1);
    check("walk cube_done reload", {4'd0, cube_done}, 32'h1);
    check("walk final cube", {4'd0, position_qb}, {4'd0, R22});
    tick();
    check("walk level_clear pulse", {31'd0, level_clear}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
